iir_mac_scheduler: RTL and testbench

//  Sequencer for the cascaded-biquad IIR datapath. Shares one multiply-accumulate unit across all sections.
//  For each accepted input sample, it walks every section and every tap in order.
//  It drives the coefficient address, operand select, accumulator control and delay-line write strobes.
//  It flags completion and dropped samples. Sits between the 48 kHz sample source and the iir_filter MAC/state RAM.

---
 rtl/iir_mac_scheduler.sv | 112 +++++++++++
 tb/tb_iir_mac_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_scheduler.sv
// Sequencer for the cascaded-biquad IIR datapath.
// It time-shares one MAC across all sections. For each accepted sample it
// walks sections 0..NUM_SECTIONS-1 and, inside each section, taps b0,b1,b2,a1,a2.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for sample_valid
//   MAC   | one multiply-accumulate for tap k of section s
//   WB    | shift the section's delay lines; its result feeds section s+1
//   DONE  | final section result on the datapath, out_valid pulse
//
// The control outputs are decoded only from the state/s/k flops, so each one
// is valid for the whole cycle of its state. An asynchronous reset clears
// them in the same cycle.
module iir_mac_scheduler #(
    parameter int NUM_SECTIONS = 4,
    parameter int TAPS         = 5,
    parameter int SEC_W        = 4,
    parameter int CADDR_W      = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic               overrun_clr,
    output logic               busy,
    output logic [SEC_W-1:0]   sec_idx,
    output logic [2:0]         tap_sel,
    output logic [CADDR_W-1:0] coef_addr,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               state_we,
    output logic               out_valid,
    output logic               overrun,
    output logic [15:0]        sample_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [SEC_W-1:0] S_LAST = SEC_W'(NUM_SECTIONS - 1);
    localparam logic [2:0]       K_LAST = 3'(TAPS - 1);

    logic [1:0]       state;
    logic [SEC_W-1:0] s;
    logic [2:0]       k;
    logic             ovr_q;
    logic [15:0]      cnt_q;

    // Section/tap walk: TAPS MAC cycles, then one write-back per section.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state <= MAC;
                        s     <= '0;
                        k     <= '0;
                    end
                end
                MAC: begin
                    if (k == K_LAST) state <= WB;
                    else             k     <= k + 3'd1;
                end
                WB: begin
                    if (s == S_LAST) begin
                        state <= DONE;
                    end else begin
                        s     <= s + 1'b1;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overrun: a sample arriving while busy is dropped. If a set and
    // a clear happen in the same cycle, the set takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  ovr_q <= 1'b0;
        else if (sample_valid && state != IDLE)   ovr_q <= 1'b1;
        else if (overrun_clr)                     ovr_q <= 1'b0;
    end

    // Completed-sample counter, silently wrapping modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt_q <= '0;
        else if (state == DONE) cnt_q <= cnt_q + 16'd1;
    end

    // Output decode from the current state.
    always_comb begin
        busy      = (state != IDLE);
        acc_en    = (state == MAC);
        acc_clr   = (state == MAC) && (k == 3'd0);
        state_we  = (state == WB);
        out_valid = (state == DONE);
        sec_idx   = (state == MAC || state == WB) ? s : '0;
        tap_sel   = (state == MAC) ? k : 3'd0;
        coef_addr = CADDR_W'(sec_idx) * CADDR_W'(TAPS) + CADDR_W'(tap_sel);
        overrun    = ovr_q;
        sample_cnt = cnt_q;
    end

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Directed testbench for iir_mac_scheduler with the default configuration (N=4, TAPS=5).
module tb_iir_mac_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic        overrun_clr;
    logic        busy;
    logic [3:0]  sec_idx;
    logic [2:0]  tap_sel;
    logic [6:0]  coef_addr;
    logic        acc_clr;
    logic        acc_en;
    logic        state_we;
    logic        out_valid;
    logic        overrun;
    logic [15:0] sample_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    iir_mac_scheduler dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .overrun_clr(overrun_clr),
        .busy(busy), .sec_idx(sec_idx), .tap_sel(tap_sel), .coef_addr(coef_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .state_we(state_we), .out_valid(out_valid),
        .overrun(overrun), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Raise sample_valid so that it is accepted at the next rising edge (cycle 0).
    // Afterwards, each @(negedge clk) lands in cycle 1, 2, ...
    task automatic start_sample();
        @(negedge clk);
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, sec_idx, tap_sel, coef_addr, acc_clr, acc_en, state_we, out_valid, overrun, sample_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b sec=%0d tap=%0d addr=%0d clr=%b en=%b we=%b ov=%b ovr=%b cnt=%0d exp all 0",
                     busy, sec_idx, tap_sel, coef_addr, acc_clr, acc_en, state_we, out_valid, overrun, sample_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        int  n_en = 0;
        logic mac, wb;
        start_sample();
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            mac = (c <= 24) && ((c - 1) % 6 < 5);
            wb  = (c <= 24) && ((c - 1) % 6 == 5);
            if (acc_en === 1'b1) n_en++;
            total++;
            if (acc_en !== mac) begin bad++; $display("FAIL single_acc_en c=%0d got=%b exp=%b", c, acc_en, mac); end
            total++;
            if (acc_clr !== (mac && ((c - 1) % 6 == 0))) begin bad++; $display("FAIL single_acc_clr c=%0d got=%b exp=%b", c, acc_clr, mac && ((c - 1) % 6 == 0)); end
            total++;
            if (state_we !== wb) begin bad++; $display("FAIL single_state_we c=%0d got=%b exp=%b", c, state_we, wb); end
            total++;
            if (out_valid !== (c == 25)) begin bad++; $display("FAIL single_out_valid c=%0d got=%b exp=%b", c, out_valid, c == 25); end
            total++;
            if (busy !== (c <= 25)) begin bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, c <= 25); end
        end
        exp_cnt++;
        total++;
        if (n_en != 20) begin bad++; $display("FAIL single_en_count got=%0d exp=20", n_en); end
        total++;
        if (sample_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL single_sample_cnt got=%0d exp=%0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_addr_walk();
        int es, et, ea;
        logic active;
        start_sample();
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            active = (c <= 24);
            es = active ? (c - 1) / 6 : 0;
            et = (active && ((c - 1) % 6 < 5)) ? (c - 1) % 6 : 0;
            ea = es * 5 + et;
            total++;
            if (sec_idx !== 4'(es)) begin bad++; $display("FAIL walk_sec_idx c=%0d got=%0d exp=%0d", c, sec_idx, es); end
            total++;
            if (tap_sel !== 3'(et)) begin bad++; $display("FAIL walk_tap_sel c=%0d got=%0d exp=%0d", c, tap_sel, et); end
            total++;
            if (coef_addr !== 7'(ea)) begin bad++; $display("FAIL walk_coef_addr c=%0d got=%0d exp=%0d", c, coef_addr, ea); end
        end
        exp_cnt++;
    endtask

    task automatic test_overrun();
        start_sample();
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            total++;
            if (overrun !== (c >= 11)) begin bad++; $display("FAIL ovr_flag c=%0d got=%b exp=%b", c, overrun, c >= 11); end
            total++;
            if (out_valid !== (c == 25)) begin bad++; $display("FAIL ovr_out_valid c=%0d got=%b exp=%b", c, out_valid, c == 25); end
            sample_valid = (c == 10);
        end
        sample_valid = 1'b0;
        exp_cnt++;
        total++;
        if (sample_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL ovr_dropped_cnt got=%0d exp=%0d", sample_cnt, exp_cnt); end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        // Clear and new overrun together: set wins.
        start_sample();
        @(negedge clk);
        sample_valid = 1'b1; overrun_clr = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b exp=1", overrun); end
        repeat (26) @(negedge clk);
        exp_cnt++;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear2 got=%b exp=0", overrun); end
    endtask

    task automatic test_back_to_back();
        start_sample();
        sample_valid = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (c == 25 || c == 51 || c == 77)) begin
                bad++; $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, out_valid, c == 25 || c == 51 || c == 77);
            end
            if (c == 27 || c == 53) begin
                total++;
                if (acc_clr !== 1'b1 || sec_idx !== 4'd0) begin
                    bad++; $display("FAIL b2b_restart c=%0d got clr=%b sec=%0d exp clr=1 sec=0", c, acc_clr, sec_idx);
                end
            end
        end
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
        sample_valid = 1'b0;
        repeat (30) @(negedge clk);
        exp_cnt += 4;
        total++;
        if (sample_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_sample_cnt got=%0d exp=%0d", sample_cnt, exp_cnt); end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_sample();
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            sample_valid = (c == 5);
        end
        sample_valid = 1'b0;
        total++;
        if (sec_idx !== 4'd2 || tap_sel !== 3'd3 || coef_addr !== 7'd13 || overrun !== 1'b1) begin
            bad++; $display("FAIL midrst_pre got sec=%0d tap=%0d addr=%0d ovr=%b exp sec=2 tap=3 addr=13 ovr=1",
                            sec_idx, tap_sel, coef_addr, overrun);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, sec_idx, tap_sel, coef_addr, acc_clr, acc_en, state_we, out_valid, overrun, sample_cnt} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got busy=%b sec=%0d tap=%0d addr=%0d clr=%b en=%b ovr=%b cnt=%0d exp all 0",
                     busy, sec_idx, tap_sel, coef_addr, acc_clr, acc_en, overrun, sample_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        start_sample();
        @(negedge clk);
        total++;
        if (sec_idx !== 4'd0 || tap_sel !== 3'd0 || coef_addr !== 7'd0 || acc_clr !== 1'b1) begin
            bad++; $display("FAIL midrst_restart1 got sec=%0d tap=%0d addr=%0d clr=%b exp 0 0 0 1", sec_idx, tap_sel, coef_addr, acc_clr);
        end
        @(negedge clk);
        total++;
        if (tap_sel !== 3'd1 || coef_addr !== 7'd1 || acc_clr !== 1'b0) begin
            bad++; $display("FAIL midrst_restart2 got tap=%0d addr=%0d clr=%b exp 1 1 0", tap_sel, coef_addr, acc_clr);
        end
        repeat (25) @(negedge clk);
        exp_cnt++;
        total++;
        if (sample_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL midrst_cnt got=%0d exp=%0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.cnt_q;
        @(negedge clk);
        total++;
        if (sample_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", sample_cnt); end
        start_sample();
        repeat (25) @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || sample_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_done got ov=%b cnt=%h exp ov=1 cnt=ffff", out_valid, sample_cnt);
        end
        @(negedge clk);
        total++;
        if (sample_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", sample_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr_walk();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
